// File: rtl/prog_load_ctrl.sv
// Load/run sequencer for the 32x16 instruction memory: streams a program in,
// holds the CPU in reset while loading, runs it free or single-step, and freezes it on halt.
module prog_load_ctrl #(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 5,
  parameter int          PC_W      = 8,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter logic [15:0] MAX_CYC   = 16'd1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_reset,
  output logic              cpu_run,
  input  logic              step_mode,
  input  logic              step_req,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   load_count,
  output logic              halted,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_HALT = 2'b11
  } state_t;

  state_t            cur_state, nxt_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [15:0]       cyc_cnt;
  logic              step_q;
  logic              pc_ok, is_halt, xfer, step_pulse, wdog_hit;

  // Loader handshake: a word moves only on a cycle where ld_valid and ld_ready are both high;
  // ld_ready is high exactly while in LOAD, and ld_valid alone never writes.
  assign ld_ready    = (cur_state == S_LOAD);
  assign xfer        = ld_valid & ld_ready;

  // Addresses at or above DEPTH fetch the halt word so the CPU stops instead of aliasing.
  assign pc_ok       = (pc[PC_W-1:ADDR_W] == '0);
  assign instruction = pc_ok ? mem[pc[ADDR_W-1:0]] : HALT_WORD;
  assign is_halt     = (instruction == HALT_WORD);

  assign step_pulse  = step_req & ~step_q;
  assign cpu_run     = (cur_state == S_RUN) & ~is_halt & (~step_mode | step_pulse);
  assign wdog_hit    = cpu_run & (cyc_cnt == MAX_CYC - 16'd1);
  assign state       = cur_state;

  always_comb begin
    nxt_state = cur_state;
    cpu_reset = 1'b0;
    halted    = 1'b0;
    case (cur_state)
      S_IDLE: begin
        cpu_reset = 1'b1;
        if (load_start) nxt_state = S_LOAD;
      end
      S_LOAD: begin
        cpu_reset = 1'b1;
        if (xfer && (ld_last || wr_ptr == ADDR_W'(DEPTH - 1))) nxt_state = S_RUN;
      end
      S_RUN: begin
        if (load_start)             nxt_state = S_LOAD;
        else if (is_halt || wdog_hit) nxt_state = S_HALT;
      end
      S_HALT: begin
        halted = 1'b1;
        if (load_start) nxt_state = S_LOAD;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state  <= S_IDLE;
      wr_ptr     <= '0;
      load_count <= '0;
      err        <= 1'b0;
      cyc_cnt    <= '0;
      step_q     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      step_q    <= step_req;
      if (nxt_state == S_LOAD && cur_state != S_LOAD) begin
        wr_ptr     <= '0;
        load_count <= '0;
        err        <= 1'b0;
      end else if (xfer) begin
        wr_ptr     <= wr_ptr + 1'b1;
        load_count <= load_count + 1'b1;
      end
      if (cur_state == S_RUN && !load_start && (!pc_ok || wdog_hit)) err <= 1'b1;
      // Holding the counter at zero outside RUN gives a fresh count on every entry.
      if (cur_state != S_RUN) cyc_cnt <= '0;
      else if (cpu_run)       cyc_cnt <= cyc_cnt + 16'd1;
    end
  end

  // Memory has no reset so a partially loaded program survives a reset.
  always_ff @(posedge clk) begin
    if (reset && xfer) mem[wr_ptr] <= ld_data;
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl: reference memory model plus an expected-instruction queue.
module tb_prog_load_ctrl;

  logic        clk = 1'b0;
  logic        reset, load_start, ld_valid, ld_last, ld_ready;
  logic [15:0] ld_data, instruction;
  logic [7:0]  pc;
  logic        cpu_reset, cpu_run, step_mode, step_req, halted, err;
  logic [1:0]  state;
  logic [5:0]  load_count;

  logic [15:0] model_mem [32];
  logic [15:0] wbuf [64];
  logic [15:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  prog_load_ctrl dut (
    .clk(clk), .reset(reset), .load_start(load_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .pc(pc),
    .instruction(instruction), .cpu_reset(cpu_reset), .cpu_run(cpu_run),
    .step_mode(step_mode), .step_req(step_req), .state(state),
    .load_count(load_count), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_words(input int n);
    for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom_range(0, 16'hFFFE));
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Streams wbuf[0..n-1]; the model records only words the controller should accept.
  task automatic stream(input int n, input int last_idx);
    bit done = 1'b0;
    int wp   = 0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = wbuf[i];
      ld_last  = (i == last_idx);
      @(negedge clk);
      check("ld_ready", 32'(ld_ready), 32'(!done));
      if (!done) begin
        model_mem[wp] = wbuf[i];
        if (i == last_idx || wp == 31) done = 1'b1;
        wp++;
      end
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input int p);
    logic [15:0] e;
    pc = 8'(p);
    exp_q.push_back((p < 32) ? model_mem[p] : 16'hFFFF);
    @(negedge clk);
    e = exp_q.pop_front();
    check("instruction", 32'(instruction), 32'(e));
    check("cpu_run", 32'(cpu_run), 32'(e != 16'hFFFF));
    check("cpu_reset_run", 32'(cpu_reset), 32'd0);
    tick();
  endtask

  task automatic count_runs(input int n, inout int runs);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpu_run) runs++;
      tick();
    end
  endtask

  initial begin
    int runs;
    reset = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = '0; pc = '0; step_mode = 1'b0; step_req = 1'b0;

    // 1: reset
    tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    tick();

    // 2: five-word program ending in the halt word
    fill_words(5);
    wbuf[4] = 16'hFFFF;
    start_load();
    stream(5, 4);
    for (int p = 0; p < 5; p++) fetch(p);
    @(negedge clk);
    check("t2_load_count", 32'(load_count), 32'd5);
    check("t2_state_halt", 32'(state), 32'd3);
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t2_cpu_run", 32'(cpu_run), 32'd0);
    tick();

    // 3: 33 words without ld_last; memory full ends the load
    fill_words(33);
    start_load();
    stream(33, -1);
    @(negedge clk);
    check("t3_load_count", 32'(load_count), 32'd32);
    check("t3_state_run", 32'(state), 32'd2);
    check("t3_err", 32'(err), 32'd0);
    tick();

    // 4: single-step
    step_mode = 1'b1;
    fill_words(2);
    start_load();
    stream(2, 1);
    pc = 8'd0;
    runs = 0;
    count_runs(3, runs);
    check("t4_idle_runs", 32'(runs), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step_req = 1'b1;
      count_runs(2, runs);
      step_req = 1'b0;
      count_runs(2, runs);
    end
    check("t4_toggle_runs", 32'(runs), 32'd3);
    runs = 0;
    step_req = 1'b1;
    count_runs(10, runs);
    step_req = 1'b0;
    check("t4_hold_runs", 32'(runs), 32'd1);
    step_mode = 1'b0;

    // 5a: pc out of range
    fill_words(2);
    start_load();
    stream(2, 1);
    fetch(40);
    @(negedge clk);
    check("t5a_err", 32'(err), 32'd1);
    check("t5a_state", 32'(state), 32'd3);
    tick();

    // 5b: watchdog on a program with no halt word
    fill_words(3);
    start_load();
    stream(3, 2);
    pc = 8'd0;
    runs = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (c == 0) check("t5b_err_clr", 32'(err), 32'd0);
      if (state != 2'b10) break;
      if (cpu_run) runs++;
      tick();
    end
    check("t5b_halted", 32'(halted), 32'd1);
    check("t5b_runs", 32'(runs), 32'd1000);
    check("t5b_err", 32'(err), 32'd1);
    tick();

    // 6: reset mid-load keeps the partial program
    fill_words(3);
    start_load();
    stream(3, -1);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    check("t6_state_idle", 32'(state), 32'd0);
    check("t6_load_count", 32'(load_count), 32'd0);
    check("t6_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    fill_words(1);
    start_load();
    stream(1, 0);
    for (int p = 0; p < 4; p++) fetch(p);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    check("t6_abort_state", 32'(state), 32'd1);
    check("t6_abort_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
